// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block: segment patterns,
// error codes, FSM state encoding and digit-select values.
package seg7_pkg;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] Seg0 = 7'h40;
  localparam logic [6:0] Seg1 = 7'h79;
  localparam logic [6:0] Seg2 = 7'h24;
  localparam logic [6:0] Seg3 = 7'h30;
  localparam logic [6:0] Seg4 = 7'h19;
  localparam logic [6:0] Seg5 = 7'h12;
  localparam logic [6:0] Seg6 = 7'h02;
  localparam logic [6:0] Seg7 = 7'h78;
  localparam logic [6:0] Seg8 = 7'h00;
  localparam logic [6:0] Seg9 = 7'h18;
  localparam logic [6:0] SegA = 7'h08;
  localparam logic [6:0] SegB = 7'h03;
  localparam logic [6:0] SegC = 7'h46;
  localparam logic [6:0] SegD = 7'h21;
  localparam logic [6:0] SegE = 7'h06;
  localparam logic [6:0] SegF = 7'h0E;

  localparam logic [1:0] ErrNone       = 2'b00;
  localparam logic [1:0] ErrBadPattern = 2'b01;
  localparam logic [1:0] ErrSequence   = 2'b10;
  localparam logic [1:0] ErrTimeout    = 2'b11;

  localparam logic [2:0] SelHex0 = 3'b001;
  localparam logic [2:0] SelHex1 = 3'b010;
  localparam logic [2:0] SelHex2 = 3'b100;

  typedef enum logic [1:0] {
    StW0 = 2'd0,
    StW1 = 2'd1,
    StW2 = 2'd2
  } state_e;

  // Digit select that the given state is waiting for.
  function automatic logic [2:0] expected_sel(state_e st);
    logic [2:0] sel;
    sel = SelHex0;
    case (st)
      StW0:    sel = SelHex0;
      StW1:    sel = SelHex1;
      StW2:    sel = SelHex2;
      default: sel = SelHex0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational exact-match decoder from an active-low segment pattern to a
// hex nibble; ok_o is low for any pattern outside the sixteen known glyphs.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       ok_o
);

  always_comb begin
    nibble_o = 4'h0;
    ok_o     = 1'b1;
    case (seg_i)
      Seg0:    nibble_o = 4'h0;
      Seg1:    nibble_o = 4'h1;
      Seg2:    nibble_o = 4'h2;
      Seg3:    nibble_o = 4'h3;
      Seg4:    nibble_o = 4'h4;
      Seg5:    nibble_o = 4'h5;
      Seg6:    nibble_o = 4'h6;
      Seg7:    nibble_o = 4'h7;
      Seg8:    nibble_o = 4'h8;
      Seg9:    nibble_o = 4'h9;
      SegA:    nibble_o = 4'hA;
      SegB:    nibble_o = 4'hB;
      SegC:    nibble_o = 4'hC;
      SegD:    nibble_o = 4'hD;
      SegE:    nibble_o = 4'hE;
      SegF:    nibble_o = 4'hF;
      default: ok_o     = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_hex.sv
// Captures three strobed seven-segment digits (HEX0, HEX1, HEX2) into a 10-bit
// value, publishing it only once the same frame has been seen STABLE_FRAMES times.
module seg7_to_hex
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [2:0] dig_sel,
  input  logic       seg_stb,
  output logic [9:0] value,
  output logic       value_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [3:0]  StableCnt   = 4'(STABLE_FRAMES);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [3:0] dec_nib;
  logic       dec_ok;

  seg7_decode u_decode (
    .seg_i    (seg_in),
    .nibble_o (dec_nib),
    .ok_o     (dec_ok)
  );

  state_e      state_q, state_d;
  logic [3:0]  nib0_q, nib0_d;
  logic [3:0]  nib1_q, nib1_d;
  logic [15:0] idle_q, idle_d;
  logic [9:0]  prev_q, prev_d;
  logic [3:0]  stab_q, stab_d;
  logic [9:0]  value_q, value_d;
  logic        vv_q, vv_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        err_hit;
  logic [1:0]  err_cause;
  logic        frame_done;
  logic [9:0]  frame;
  logic        frame_match;

  assign frame       = {dec_nib[1:0], nib1_q, nib0_q};
  assign frame_match = (frame == prev_q);

  always_comb begin
    state_d    = state_q;
    nib0_d     = nib0_q;
    nib1_d     = nib1_q;
    idle_d     = idle_q;
    prev_d     = prev_q;
    stab_d     = stab_q;
    value_d    = value_q;
    vv_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    err_hit    = 1'b0;
    err_cause  = ErrNone;
    frame_done = 1'b0;

    if (seg_stb) begin
      idle_d = '0;
      if (dig_sel == expected_sel(state_q)) begin
        // HEX2 only carries the top two value bits, so digits above 3 are rejected.
        if (!dec_ok || (state_q == StW2 && dec_nib > 4'd3)) begin
          err_hit   = 1'b1;
          err_cause = ErrBadPattern;
        end else begin
          case (state_q)
            StW0: begin
              nib0_d  = dec_nib;
              state_d = StW1;
            end
            StW1: begin
              nib1_d  = dec_nib;
              state_d = StW2;
            end
            StW2: begin
              frame_done = 1'b1;
              state_d    = StW0;
            end
            default: state_d = StW0;
          endcase
        end
      end else if (dig_sel == SelHex0 && dec_ok) begin
        // A fresh HEX0 out of turn restarts the frame rather than flagging an error.
        nib0_d  = dec_nib;
        state_d = StW1;
      end else begin
        err_hit   = 1'b1;
        err_cause = ErrSequence;
      end
    end else if (state_q != StW0) begin
      if (idle_q == TimeoutLast) begin
        err_hit   = 1'b1;
        err_cause = ErrTimeout;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end

    if (frame_done) begin
      if (frame_match) begin
        stab_d = (stab_q == StableCnt) ? stab_q : stab_q + 4'd1;
      end else begin
        stab_d = 4'd1;
      end
      // Publish only on the first arrival at the threshold; a differing frame re-arms.
      vv_d   = (stab_d == StableCnt) && (!frame_match || stab_q != StableCnt);
      prev_d = frame;
      if (vv_d) begin
        value_d = frame;
      end
    end

    if (err_hit) begin
      err_d   = 1'b1;
      code_d  = err_cause;
      state_d = StW0;
      stab_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StW0;
      nib0_q  <= '0;
      nib1_q  <= '0;
      idle_q  <= '0;
      prev_q  <= '0;
      stab_q  <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
    end else begin
      state_q <= state_d;
      nib0_q  <= nib0_d;
      nib1_q  <= nib1_d;
      idle_q  <= idle_d;
      prev_q  <= prev_d;
      stab_q  <= stab_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign value       = value_q;
  assign value_valid = vv_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign busy        = (state_q != StW0);

endmodule

// File: tb/tb_seg7_to_hex.sv
// Bench for seg7_to_hex: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seg7_to_hex;

  localparam int Stable  = 2;
  localparam int Timeout = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [2:0] dig_sel;
  logic       seg_stb;
  logic [9:0] value;
  logic       value_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_to_hex #(
    .STABLE_FRAMES (Stable),
    .TIMEOUT       (Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .seg_stb     (seg_stb),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits captured so far, idle time, stability bookkeeping.
  int pats[16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                   'h00, 'h18, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
  int m_digs[3];
  int m_n, m_idle, m_stab, m_prev, m_value, m_code;
  bit m_vv, m_err;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pats[i] == int'(s)) return i;
    return -1;
  endfunction

  function automatic int sel_index(input logic [2:0] d);
    if (d == 3'b001) return 0;
    if (d == 3'b010) return 1;
    if (d == 3'b100) return 2;
    return -1;
  endfunction

  task automatic model_error(input int code);
    m_err  = 1;
    m_code = code;
    m_n    = 0;
    m_stab = 0;
  endtask

  always @(posedge clk) begin
    int idx, f;
    bit was_stable;
    if (rst) begin
      m_n = 0; m_idle = 0; m_stab = 0; m_prev = 0; m_value = 0;
      m_code = 0; m_vv = 0; m_err = 0;
    end else begin
      m_vv  = 0;
      m_err = 0;
      if (seg_stb) begin
        idx    = lookup(seg_in);
        m_idle = 0;
        if (sel_index(dig_sel) == m_n) begin
          if (idx < 0 || (m_n == 2 && idx > 3)) begin
            model_error(1);
          end else begin
            m_digs[m_n] = idx;
            m_n++;
            if (m_n == 3) begin
              m_n        = 0;
              f          = m_digs[2] * 256 + m_digs[1] * 16 + m_digs[0];
              was_stable = (m_stab == Stable);
              if (f == m_prev) m_stab = (m_stab < Stable) ? m_stab + 1 : Stable;
              else m_stab = 1;
              if (m_stab == Stable && (f != m_prev || !was_stable)) begin
                m_vv    = 1;
                m_value = f;
              end
              m_prev = f;
            end
          end
        end else if (dig_sel == 3'b001 && idx >= 0) begin
          m_digs[0] = idx;
          m_n       = 1;
        end else begin
          model_error(2);
        end
      end else if (m_n != 0) begin
        m_idle++;
        if (m_idle == Timeout) begin
          m_idle = 0;
          model_error(3);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_value", 32'(value), 32'(m_value));
    check("cyc_value_valid", 32'(value_valid), 32'(m_vv));
    check("cyc_err", 32'(err), 32'(m_err));
    check("cyc_err_code", 32'(err_code), 32'(m_code));
    check("cyc_busy", 32'(busy), 32'(m_n != 0));
  end

  task automatic strobe(input logic [2:0] d, input logic [6:0] s);
    seg_stb = 1'b1;
    dig_sel = d;
    seg_in  = s;
    @(negedge clk);
    seg_stb = 1'b0;
    dig_sel = 3'b000;
    seg_in  = 7'h7F;
  endtask

  task automatic frame(input logic [6:0] h0, input logic [6:0] h1, input logic [6:0] h2);
    strobe(3'b001, h0);
    strobe(3'b010, h1);
    strobe(3'b100, h2);
  endtask

  initial begin
    rst     = 1'b1;
    seg_stb = 1'b0;
    dig_sel = 3'b000;
    seg_in  = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 5/A/2 twice publishes 2A5h once; a third copy stays quiet.
    frame(7'h12, 7'h08, 7'h24);
    check("stab_first_vv", 32'(value_valid), 32'h0);
    frame(7'h12, 7'h08, 7'h24);
    check("stab_second_vv", 32'(value_valid), 32'h1);
    check("stab_second_value", 32'(value), 32'h2A5);
    frame(7'h12, 7'h08, 7'h24);
    check("stab_third_vv", 32'(value_valid), 32'h0);

    // Unknown glyph on HEX1.
    strobe(3'b001, 7'h40);
    strobe(3'b010, 7'h7F);
    check("bad_err", 32'(err), 32'h1);
    check("bad_code", 32'(err_code), 32'h1);
    check("bad_busy", 32'(busy), 32'h0);
    check("bad_value_kept", 32'(value), 32'h2A5);

    // Out-of-order digit, then an out-of-turn HEX0 restart.
    strobe(3'b001, 7'h79);
    strobe(3'b100, 7'h40);
    check("seq_err", 32'(err), 32'h1);
    check("seq_code", 32'(err_code), 32'h2);
    strobe(3'b001, 7'h79);
    strobe(3'b001, 7'h30);
    check("restart_err", 32'(err), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);

    // Ten idle cycles expire the frame; a strobe on the tenth saves it.
    strobe(3'b001, 7'h40);
    repeat (9) @(negedge clk);
    check("to_pre_err", 32'(err), 32'h0);
    check("to_pre_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("to_err", 32'(err), 32'h1);
    check("to_code", 32'(err_code), 32'h3);
    check("to_busy", 32'(busy), 32'h0);
    strobe(3'b001, 7'h40);
    repeat (9) @(negedge clk);
    strobe(3'b010, 7'h40);
    check("to_race_err", 32'(err), 32'h0);
    check("to_race_busy", 32'(busy), 32'h1);

    // HEX2 digit 4 is out of range.
    strobe(3'b100, 7'h19);
    check("hex2_err", 32'(err), 32'h1);
    check("hex2_code", 32'(err_code), 32'h1);

    // Reset mid-frame, coincident with a strobe.
    strobe(3'b001, 7'h40);
    strobe(3'b010, 7'h40);
    rst     = 1'b1;
    seg_stb = 1'b1;
    dig_sel = 3'b100;
    seg_in  = 7'h30;
    @(negedge clk);
    seg_stb = 1'b0;
    dig_sel = 3'b000;
    seg_in  = 7'h7F;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_vv", 32'(value_valid), 32'h0);
    check("mid_rst_code", 32'(err_code), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    frame(7'h40, 7'h40, 7'h30);
    check("post_rst_first_vv", 32'(value_valid), 32'h0);
    frame(7'h40, 7'h40, 7'h30);
    check("post_rst_vv", 32'(value_valid), 32'h1);
    check("post_rst_value", 32'(value), 32'h300);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_to_hex.md
SEG7_TO_HEX -- requirements
Module: seg7_to_hex

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- STABLE_FRAMES, 2, consecutive identical decoded frames required before value_valid; legal range 1..15.
- TIMEOUT, 1000, idle cycles allowed between strobes inside a frame before abort; legal range 2..65535.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic rising-edge.
- rst, input, 1, synchronous, active-high reset.
- seg_in, input, 7, active-low segment pattern, bit order gfedcba.
- dig_sel, input, 3, one-hot digit select: bit0=HEX0, bit1=HEX1, bit2=HEX2.
- seg_stb, input, 1, one-cycle strobe qualifying seg_in/dig_sel.
- value, output, 10, last accepted value: {HEX2[1:0], HEX1, HEX0}.
- value_valid, output, 1, one-cycle pulse when value updates.
- err, output, 1, one-cycle error pulse.
- err_code, output, 2, cause, held until next err: 01 bad pattern, 10 sequence, 11 timeout.
- busy, output, 1, high while a frame is partially captured.

Function
REQ-003 Decoding SHALL be exact-match on the 16 active-low patterns: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=18h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh; any other pattern is invalid.
REQ-004 FSM states SHALL be W0, W1 and W2, and the FSM SHALL reset to W0.
REQ-005 Transitions SHALL follow the expected digit: W0 needs dig_sel=001, W1 needs 010, W2 needs 100; a valid strobe stores the nibble and advances W0->W1->W2->W0.
REQ-006 In W2, a decoded digit greater than 3 SHALL count as a bad pattern.
REQ-007 A bad pattern SHALL pulse err with err_code=01, discard the partial frame and return to W0.
REQ-008 A strobe with the wrong digit, or with a dig_sel that is not one-hot, SHALL pulse err with err_code=10 and return to W0.
REQ-009 Exception to REQ-008: if the wrong-digit strobe has dig_sel=001 and a valid pattern, it SHALL restart the frame, with no err, and move to W1.
REQ-010 An idle counter SHALL run in W1/W2 and clear on every strobe; reaching TIMEOUT SHALL pulse err with err_code=11 and return to W0.
REQ-011 A strobe and a timeout in the same cycle SHALL resolve in favour of the strobe.
REQ-012 A completed frame SHALL be compared with the previous completed frame; a match increments the stability count, saturating at STABLE_FRAMES, and a mismatch sets the count to 1.
REQ-013 value_valid SHALL pulse and value SHALL load in the cycle after the completing HEX2 strobe, only when the count first reaches STABLE_FRAMES.
REQ-014 Further identical frames SHALL NOT re-pulse value_valid; the first differing frame re-arms it.
REQ-015 An error SHALL clear the stability count to 0 but SHALL NOT alter value.
REQ-016 busy SHALL equal (state != W0).
REQ-017 Outputs SHALL be registered, with a latency of 1 cycle from strobe to err or value_valid; seg_stb=0 inputs SHALL be ignored.

Reset
REQ-018 While rst=1, the block SHALL hold value=0, value_valid=0, err=0, err_code=00, busy=0, state=W0, and all counters and stored nibbles at 0.
REQ-019 rst SHALL take priority over a coincident strobe.
REQ-020 Reset mid-frame SHALL discard the partial frame, with no err pulse.

Structure
REQ-021 Package seg7_pkg SHALL hold the 16 pattern constants, the err_code constants and the FSM state encoding.
REQ-022 Sub-module seg7_decode SHALL be purely combinational, mapping seg_in to {nibble[3:0], ok} and instantiated once.

Verification
REQ-023 Bench SHALL cover, STABLE_FRAMES=2: frame 12h/08h/24h sent twice -> one value_valid after the 2nd HEX2 strobe, value=2A5h; 3rd identical frame -> no pulse.
REQ-024 Bench SHALL cover: HEX0=40h, HEX1=7Fh -> err, err_code=01, busy=0; value unchanged.
REQ-025 Bench SHALL cover: HEX0=79h then a HEX2 strobe -> err, err_code=10; then HEX0=79h, HEX0=30h -> no err, busy=1.
REQ-026 Bench SHALL cover, TIMEOUT=10: HEX0 strobe, then 10 idle cycles -> err, err_code=11 on cycle 10; a strobe on cycle 10 instead -> no err.
REQ-027 Bench SHALL cover: HEX2 pattern 19h (4) -> err, err_code=01.
REQ-028 Bench SHALL cover: rst pulse after HEX1 -> busy=0, outputs zero; a following full double frame 40h/40h/30h -> value=300h.
